mem_port_arbiter: RTL

Sequencing arbiter that shares the processor's single unified instruction/data memory between two requesters: the multi-cycle core (fetch, load and store accesses selected by IoD/MemR/MemW) and an auxiliary port (program loader / debug). It serialises accesses, drives the memory for a fixed read latency, returns read data, and acknowledges exactly one requester per access. It sits between the core's memory interface and the memory macro.

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one unified instruction/data memory between the multi-cycle core
// and an auxiliary (loader/debug) port. One access at a time: the winner's
// attributes are latched, the memory is driven for MEM_LAT cycles, read data
// is captured on the last of them, and the winner gets a one-cycle ack.
//
// Parameters: ADDR_W, DATA_W, MEM_LAT (>=1, memory cycles per access)
// Ports:
//   CLK, Reset_n                    clock (rising), async active-low reset
//   core_req/we/addr/wdata, core_ack   core request port and completion pulse
//   aux_req/we/addr/wdata,  aux_ack    auxiliary request port and completion pulse
//   rdata                           data of the last completed read
//   mem_en/we/addr/wdata, mem_rdata memory macro interface
//   busy                            high while an access or its ack is in flight
//   owner                           0 = core, 1 = aux; current/last access owner
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise the core has fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ack,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int CNT_W = $clog2(MEM_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             grant_aux;

`ifdef MEM_ARB_RR_EN
    // Last granted requester; on contention the other one wins.
    logic rr_last;

    always_comb begin
        grant_aux = aux_req && (!core_req || !rr_last);
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_last <= 1'b1;
        end else if (state == S_IDLE && (core_req || aux_req)) begin
            rr_last <= grant_aux;
        end
    end
`else
    always_comb begin
        grant_aux = aux_req && !core_req;
    end
`endif

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            core_ack  <= 1'b0;
            aux_ack   <= 1'b0;
            busy      <= 1'b0;
            owner     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (core_req || aux_req) begin
                        owner     <= grant_aux;
                        mem_we    <= grant_aux ? aux_we    : core_we;
                        mem_addr  <= grant_aux ? aux_addr  : core_addr;
                        mem_wdata <= grant_aux ? aux_wdata : core_wdata;
                        mem_en    <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // cnt holds at its last value instead of wrapping.
                    if (cnt == CNT_LAST) begin
                        if (!mem_we) begin
                            rdata <= mem_rdata;
                        end
                        core_ack <= ~owner;
                        aux_ack  <= owner;
                        mem_en   <= 1'b0;
                        mem_we   <= 1'b0;
                        state    <= S_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    core_ack <= 1'b0;
                    aux_ack  <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
